coh_noc_dor_input_buffer: RTL and testbench
===========================================

// Module: coh_noc_dor_input_buffer
// PURPOSE
//  Input stage of a coherence-NoC mesh router port. It buffers incoming packets in a small
//  FIFO. It splits the destination cord into X/Y fields using the same cord-marker layout
//  as the coherence-NoC parameter block, and computes a dimension-ordered output direction.
//  It presents head packet + one-hot direction to the downstream crossbar/arbiter stage.
// PARAMETERS
//  dims_p          2    mesh dimensions; only 1 (X only) or 2 are legal
//  trans_p         0    0: XY order, cord = {y,x}; 1: YX order, cord = {x,y}
//  x_cord_width_p  10   X coordinate width
//  y_cord_width_p  20   Y coordinate width (unused when dims_p=1)
//  data_width_p    64   packet width; dest cord in bits [cord_width-1:0]
//  els_p           2    FIFO depth, >=2, power of two
//  cord markers: int [dims_p:0]
//    trans_p=0: {x_w+y_w, x_w, 0}
//    trans_p=1: {x_w+y_w, y_w, 0}
//  cord_width = markers[dims_p]
// PORTS
//  clk_i       in   1             clock
//  reset_i     in   1             synchronous reset, active-high
//  my_cord_i   in   cord_width    this router's cord (quasi-static)
//  v_i         in   1             input packet valid
//  data_i      in   data_width_p  input packet
//  ready_o     out  1             input can accept (valid/ready)
//  v_o         out  1             head packet valid
//  data_o      out  data_width_p  head packet
//  dir_o       out  5             one-hot {S,N,E,W,P}; bit0=P, 1=W, 2=E, 3=N, 4=S
//  yumi_i      in   1             downstream consumes head this cycle (valid/yumi)
// BEHAVIOUR
//  - Reset (sync): wr/rd ptrs=0, count=0.
//    ready_o=0 while reset_i=1. v_o=0. data_o=0. dir_o=0.
//  - ready_o = ~reset_i & (count != els_p). It depends only on state, never on yumi_i,
//    so a full FIFO accepts nothing even when yumi_i=1.
//  - Enqueue when v_i & ready_o. The direction is computed at enqueue from data_i and
//    my_cord_i, then stored with the packet.
//  - Latency: a packet accepted in cycle N is visible on v_o/data_o/dir_o in cycle N+1.
//    There is no same-cycle bypass.
//  - v_o = (count != 0). data_o/dir_o = head entry when v_o=1, forced to 0 when v_o=0.
//  - Dequeue on yumi_i. yumi_i with v_o=0 is illegal: the design ignores it and the bench flags it.
//  - Simultaneous enq+deq: count unchanged and both ptrs advance. Ptrs wrap mod els_p.
//  - Routing: dest/my fields are sliced at the markers.
//    trans_p=0: x=[m1-1:m0], y=[m2-1:m1].
//    trans_p=1: y=[m1-1:m0], x=[m2-1:m1].
//  - XY order (trans_p=0):
//    1. dx != mx: go E if dx > mx, else W.
//    2. Else dy != my: go S if dy > my, else N.
//    3. Else P.
//  - YX order (trans_p=1): Y test first, then X, then P.
//  - dims_p=1: only the X test applies, else P.
//  - Comparisons are unsigned. dir_o has exactly one bit set whenever v_o=1.
//  - Reset mid-traffic discards all stored packets. The first post-reset accept happens no
//    earlier than the first cycle with reset_i=0.
//  - Elaboration error if dims_p not in {1,2}, or cord_width > data_width_p.
// TESTING (defaults, els_p=2; my cord x=5,y=3 -> my_cord_i=30'h0C05)
//  - Hold reset 3 cycles with v_i=1 -> ready_o=0, v_o=0 throughout.
//    First accept happens in the first cycle after deassert.
//  - data_i=30'h0C07 (x7,y3), accepted cycle N -> cycle N+1: v_o=1, data_o=0x0C07, dir_o=5'b00100 (E).
//  - Dests (x5,y9)=0x2405 -> S 5'b10000; (x2,y3)=0x0C02 -> W; (x5,y1)=0x0405 -> N;
//    (x5,y3)=0x0C05 -> P 5'b00001.
//  - trans_p=1, my_cord x=5,y=3 (0x0500003), dest x7,y9 (0x0700009) -> S (Y first).
//    Same dest with trans_p=0 -> E.
//  - Fill 2 packets with yumi_i=0 -> ready_o=0. Then assert yumi_i=1 and v_i=1 together
//    -> no enqueue that cycle. Next cycle: count=1, ready_o=1.
//  - Stream 8 packets with v_i=1, yumi_i=v_o every cycle -> in-order delivery, ptr wrap,
//    no drops. Assert reset mid-stream -> v_o=0 next cycle, FIFO empty.

Source files
------------

// File: rtl/coh_noc_dor_input_buffer.sv
// Coherence-NoC router input stage: small packet FIFO that stores a
// dimension-ordered output direction alongside each packet.
module coh_noc_dor_input_buffer #(
    parameter int dims_p         = 2,
    parameter int trans_p        = 0,
    parameter int x_cord_width_p = 10,
    parameter int y_cord_width_p = 20,
    parameter int data_width_p   = 64,
    parameter int els_p          = 2,
    localparam int m1_lp         = (trans_p != 0) ? y_cord_width_p
                                                  : x_cord_width_p,
    localparam int cord_width_lp = (dims_p == 1) ? m1_lp
                                   : x_cord_width_p + y_cord_width_p
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [cord_width_lp-1:0] my_cord_i,
    input  logic                     v_i,
    input  logic [data_width_p-1:0]  data_i,
    output logic                     ready_o,
    output logic                     v_o,
    output logic [data_width_p-1:0]  data_o,
    output logic [4:0]               dir_o,
    input  logic                     yumi_i
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;
    localparam int x_lo_lp  = (trans_p != 0 && dims_p == 2) ? m1_lp : 0;
    localparam int y_lo_lp  = (trans_p != 0) ? 0 : m1_lp;
    localparam int wide_lp  = cord_width_lp + x_cord_width_p
                              + y_cord_width_p;

    localparam logic [cnt_w_lp-1:0] full_lp = cnt_w_lp'(els_p);

    localparam logic [4:0] dir_p_lp = 5'b00001;
    localparam logic [4:0] dir_w_lp = 5'b00010;
    localparam logic [4:0] dir_e_lp = 5'b00100;
    localparam logic [4:0] dir_n_lp = 5'b01000;
    localparam logic [4:0] dir_s_lp = 5'b10000;

    if (dims_p != 1 && dims_p != 2) begin : g_bad_dims
        $error("coh_noc_dor_input_buffer: dims_p must be 1 or 2");
    end
    if (cord_width_lp > data_width_p) begin : g_bad_width
        $error("coh_noc_dor_input_buffer: cord wider than packet");
    end
    if (els_p < 2 || (els_p & (els_p - 1)) != 0) begin : g_bad_els
        $error("coh_noc_dor_input_buffer: els_p must be a power of two >= 2");
    end

    function automatic logic [x_cord_width_p-1:0] cord_x(
        input logic [cord_width_lp-1:0] c
    );
        logic [wide_lp-1:0] s;
        s = wide_lp'(c) >> x_lo_lp;
        return s[x_cord_width_p-1:0];
    endfunction

    function automatic logic [y_cord_width_p-1:0] cord_y(
        input logic [cord_width_lp-1:0] c
    );
        logic [wide_lp-1:0] s;
        s = wide_lp'(c) >> y_lo_lp;
        return s[y_cord_width_p-1:0];
    endfunction

    logic [cord_width_lp-1:0]  dest_cord;
    logic [x_cord_width_p-1:0] dx, mx;
    logic [y_cord_width_p-1:0] dy, my;
    logic                      x_ne, y_ne;
    logic [4:0]                dir_x, dir_y, dir_in;

    assign dest_cord = data_i[cord_width_lp-1:0];
    assign dx        = cord_x(dest_cord);
    assign mx        = cord_x(my_cord_i);
    assign dy        = cord_y(dest_cord);
    assign my        = cord_y(my_cord_i);
    assign x_ne      = (dx != mx);
    assign y_ne      = (dims_p == 2) && (dy != my);
    assign dir_x     = (dx > mx) ? dir_e_lp : dir_w_lp;
    assign dir_y     = (dy > my) ? dir_s_lp : dir_n_lp;

    // The dimension resolved first depends on the routing order.
    always_comb begin
        dir_in = dir_p_lp;
        if (trans_p == 0) begin
            if (x_ne)      dir_in = dir_x;
            else if (y_ne) dir_in = dir_y;
        end else begin
            if (y_ne)      dir_in = dir_y;
            else if (x_ne) dir_in = dir_x;
        end
    end

    logic [data_width_p-1:0] data_mem [els_p];
    logic [4:0]              dir_mem  [els_p];
    logic [ptr_w_lp-1:0]     wr_ptr, rd_ptr;
    logic [cnt_w_lp-1:0]     count;
    logic                    enq, deq;

    assign ready_o = ~reset_i & (count != full_lp);
    assign v_o     = (count != '0);
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;
    assign data_o  = v_o ? data_mem[rd_ptr] : '0;
    assign dir_o   = v_o ? dir_mem[rd_ptr]  : '0;

    always_ff @(posedge clk_i) begin
        if (enq) begin
            data_mem[wr_ptr] <= data_i;
            dir_mem[wr_ptr]  <= dir_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + ptr_w_lp'(1);
            if (deq) rd_ptr <= rd_ptr + ptr_w_lp'(1);
            if (enq && !deq)      count <= count + cnt_w_lp'(1);
            else if (!enq && deq) count <= count - cnt_w_lp'(1);
        end
    end

endmodule

// File: tb/tb_coh_noc_dor_input_buffer.sv
// Bench for coh_noc_dor_input_buffer: queue-based reference model with
// a negedge monitor, plus directed routing and full-FIFO cases.
module tb_coh_noc_dor_input_buffer;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [29:0] my_cord = 30'h0000C05;
    logic        v_i, yumi_i, ready_o, v_o;
    logic [63:0] data_i, data_o;
    logic [4:0]  dir_o;

    logic [29:0] my_cord2 = 30'h0500003;
    logic        v2, yumi2, ready2, vo2;
    logic [63:0] data2, do2;
    logic [4:0]  dir2;

    always #5 clk = ~clk;

    coh_noc_dor_input_buffer u_dut (
        .clk_i(clk), .reset_i(reset_i), .my_cord_i(my_cord),
        .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .v_o(v_o), .data_o(data_o), .dir_o(dir_o), .yumi_i(yumi_i)
    );

    coh_noc_dor_input_buffer #(.trans_p(1)) u_dut_yx (
        .clk_i(clk), .reset_i(reset_i), .my_cord_i(my_cord2),
        .v_i(v2), .data_i(data2), .ready_o(ready2),
        .v_o(vo2), .data_o(do2), .dir_o(dir2), .yumi_i(yumi2)
    );

    typedef struct {
        logic [63:0] d;
        logic [4:0]  dir;
    } pkt_t;

    pkt_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Direction straight from the routing rules, on whole numbers.
    function automatic logic [4:0] ref_dir(input longint unsigned dest,
                                           input longint unsigned me,
                                           input bit trans);
        longint unsigned dx, dy, mx, my;
        if (trans) begin
            dx = (dest >> 20) % 1024; dy = dest % (1 << 20);
            mx = (me >> 20) % 1024;   my = me % (1 << 20);
            if (dy != my) return (dy > my) ? 5'b10000 : 5'b01000;
            if (dx != mx) return (dx > mx) ? 5'b00100 : 5'b00010;
        end else begin
            dx = dest % 1024; dy = (dest >> 10) % (1 << 20);
            mx = me % 1024;   my = (me >> 10) % (1 << 20);
            if (dx != mx) return (dx > mx) ? 5'b00100 : 5'b00010;
            if (dy != my) return (dy > my) ? 5'b10000 : 5'b01000;
        end
        return 5'b00001;
    endfunction

    function automatic logic [63:0] rand_pkt();
        logic [63:0] d;
        d = {$urandom, $urandom};
        d[9:0]   = 10'($urandom_range(0, 10));
        d[29:10] = 20'($urandom_range(0, 6));
        return d;
    endfunction

    // Reference FIFO: capacity 2, accept only when not full.
    always @(posedge clk) begin
        if (reset_i) begin
            q.delete();
        end else if (q.size() < 2) begin
            if (yumi_i && q.size() != 0) void'(q.pop_front());
            if (v_i) q.push_back('{data_i, ref_dir(data_i, 64'(my_cord), 1'b0)});
        end else begin
            if (yumi_i) void'(q.pop_front());
        end
        chk_en <= 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready_o", 64'(ready_o), 64'(!reset_i && q.size() < 2));
            chk("v_o", 64'(v_o), 64'(q.size() != 0));
            if (q.size() != 0) begin
                chk("data_o", data_o, q[0].d);
                chk("dir_o", 64'(dir_o), 64'(q[0].dir));
            end else begin
                chk("data_o_idle", data_o, 64'h0);
                chk("dir_o_idle", 64'(dir_o), 64'h0);
            end
            if (yumi_i && q.size() == 0) begin
                errors++;
                $display("FAIL yumi_no_valid: yumi_i=1 with empty FIFO at %0t", $time);
            end
        end
    end

    task automatic one(input logic [63:0] d, input logic [4:0] dir,
                       input string name);
        v_i = 1'b1; data_i = d;
        @(posedge clk); #1 v_i = 1'b0;
        @(negedge clk);
        chk({name, "_v"}, 64'(v_o), 64'h1);
        chk({name, "_data"}, data_o, d);
        chk({name, "_dir"}, 64'(dir_o), 64'(dir));
        #1 yumi_i = 1'b1;
        @(posedge clk); #1 yumi_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_i = 1'b1; v_i = 1'b1; data_i = 64'h0C07; yumi_i = 1'b0;
        v2 = 1'b0; data2 = '0; yumi2 = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(posedge clk); #1 v_i = 1'b0;
        @(negedge clk);
        chk("first_v", 64'(v_o), 64'h1);
        chk("first_data", data_o, 64'h0C07);
        chk("first_dir", 64'(dir_o), 64'h04);
        #1 yumi_i = 1'b1;
        @(posedge clk); #1 yumi_i = 1'b0;

        one(64'h2405, 5'b10000, "dest_S");
        one(64'h0C02, 5'b00010, "dest_W");
        one(64'h0405, 5'b01000, "dest_N");
        one(64'h0C05, 5'b00001, "dest_P");
        one(64'h0700009, 5'b00100, "xy_E");

        data2 = 64'h0700009; v2 = 1'b1;
        @(posedge clk); #1 v2 = 1'b0;
        @(negedge clk);
        chk("yx_v", 64'(vo2), 64'h1);
        chk("yx_data", do2, 64'h0700009);
        chk("yx_dir_S", 64'(dir2), 64'h10);
        chk("yx_ready", 64'(ready2), 64'h1);
        #1 yumi2 = 1'b1;
        @(posedge clk); #1 yumi2 = 1'b0;
        @(negedge clk);
        chk("yx_empty", 64'(vo2), 64'h0);

        // Fill, then offer a packet while consuming: full blocks it.
        @(posedge clk); #1 v_i = 1'b1; data_i = 64'h0C07;
        @(posedge clk); #1 data_i = 64'h2405;
        @(posedge clk); #1 data_i = 64'h0C02; yumi_i = 1'b1;
        @(negedge clk);
        chk("full_ready", 64'(ready_o), 64'h0);
        @(posedge clk); #1 v_i = 1'b0; yumi_i = 1'b0;
        @(negedge clk);
        chk("after_full_ready", 64'(ready_o), 64'h1);
        chk("after_full_head", data_o, 64'h2405);
        #1 yumi_i = 1'b1;
        @(posedge clk); #1 yumi_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            v_i = 1'b1; data_i = rand_pkt();
            yumi_i = (q.size() != 0);
            reset_i = (i == 5);
            @(posedge clk); #1;
        end
        reset_i = 1'b0;
        v_i = 1'b0; yumi_i = 1'b0;
        @(negedge clk);
        chk("post_reset_stream_v", 64'(v_o), 64'(q.size() != 0));

        for (int c = 0; c < 400; c++) begin
            #1;
            v_i = ($urandom % 4) != 0;
            data_i = rand_pkt();
            yumi_i = (q.size() != 0) && (($urandom % 3) != 0);
            reset_i = (c == 200);
            @(posedge clk);
        end
        #1 reset_i = 1'b0; v_i = 1'b0;
        yumi_i = (q.size() != 0);
        for (int k = 0; k < 4 && q.size() != 0; k++) begin
            @(posedge clk); #1 yumi_i = (q.size() != 0);
        end
        yumi_i = 1'b0;
        @(negedge clk);
        chk("drained", 64'(v_o), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
